// File: rtl/zbuf_if.sv
// Pixel stream from the rasteriser into the depth-tested framebuffer.
// A pixel transfers on a cycle where in_valid and in_ready are both high.
interface zbuf_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 8,
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [CW-1:0] in_red;
  logic [CW-1:0] in_green;
  logic [CW-1:0] in_blue;
  logic [DW-1:0] in_depth;

  modport master (
    output in_valid, in_x, in_y,
    output in_red, in_green, in_blue, in_depth,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_x, in_y,
    input  in_red, in_green, in_blue, in_depth,
    output in_ready
  );
endinterface

// File: rtl/zbuf_framebuffer.sv
// Depth-tested framebuffer: pipelined read-compare-write, clear engine
// and a synchronous scan-out read port.
module zbuf_framebuffer #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 8,
  parameter int DW = 8,
  parameter int H_RES = 64,
  parameter int V_RES = 48,
  parameter int DEPTH_LESS = 1,
  parameter logic [DW-1:0] CLEAR_DEPTH = {DW{1'b1}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  zbuf_if.slave            pix,
  input  logic             clear_start,
  input  logic [CW-1:0]    clear_red,
  input  logic [CW-1:0]    clear_green,
  input  logic [CW-1:0]    clear_blue,
  output logic             clear_busy,
  input  logic             rd_en,
  input  logic [XW-1:0]    rd_x,
  input  logic [YW-1:0]    rd_y,
  output logic             rd_valid,
  output logic [CW-1:0]    rd_red,
  output logic [CW-1:0]    rd_green,
  output logic [CW-1:0]    rd_blue,
  output logic [DW-1:0]    rd_depth,
  output logic [CNT_W-1:0] written_cnt,
  output logic [CNT_W-1:0] rejected_cnt,
  output logic [CNT_W-1:0] oob_cnt
);
  localparam int N  = H_RES * V_RES;
  localparam int AW = $clog2(N);
  localparam int WW = 3 * CW + DW;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t state, state_n;
  logic [WW-1:0] mem [N];

  logic          take, in_oob, rd_oob;
  logic [AW-1:0] in_addr, rd_addr;
  logic          clr_go, clr_last;
  logic [AW-1:0] clr_addr;
  logic [WW-1:0] clr_word;

  logic          s1_valid, s1_oob;
  logic [AW-1:0] s1_addr;
  logic [WW-1:0] s1_word, pipe_q;
  logic          fw_valid;
  logic [AW-1:0] fw_addr;
  logic [WW-1:0] fw_word, old_word;
  logic          pass, reject, oob_hit;

  logic          we;
  logic [AW-1:0] waddr;
  logic [WW-1:0] wdata, rd_word;

  assign pix.in_ready = !rst && state == RUN && !clear_start;
  assign take = pix.in_valid && pix.in_ready;
  assign clr_go = state == RUN && clear_start;
  assign clear_busy = state != RUN;
  assign clr_last = clr_addr == AW'(N - 1);

  assign in_oob = 32'(pix.in_x) >= H_RES || 32'(pix.in_y) >= V_RES;
  assign in_addr = AW'(32'(pix.in_y) * H_RES + 32'(pix.in_x));
  assign rd_oob = 32'(rd_x) >= H_RES || 32'(rd_y) >= V_RES;
  assign rd_addr = AW'(32'(rd_y) * H_RES + 32'(rd_x));

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (clear_start) state_n = DRAIN;
      DRAIN:   state_n = CLEAR;
      CLEAR:   if (clr_last) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr <= '0;
    end else if (state == DRAIN) begin
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
    end
    if (clr_go) begin
      clr_word <= {clear_red, clear_green, clear_blue, CLEAR_DEPTH};
    end
  end

  // The word written last cycle is not yet in pipe_q; forward it.
  always_comb begin
    old_word = pipe_q;
    if (fw_valid && fw_addr == s1_addr) old_word = fw_word;
    pass = 1'b0;
    if (s1_valid && !s1_oob) begin
      if (DEPTH_LESS != 0) pass = s1_word[DW-1:0] < old_word[DW-1:0];
      else                 pass = s1_word[DW-1:0] > old_word[DW-1:0];
    end
    reject  = s1_valid && !s1_oob && !pass;
    oob_hit = s1_valid && s1_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      fw_valid <= 1'b0;
    end else begin
      s1_valid <= take;
      fw_valid <= pass;
    end
    s1_oob  <= in_oob;
    s1_addr <= in_addr;
    s1_word <= {pix.in_red, pix.in_green, pix.in_blue, pix.in_depth};
    fw_addr <= s1_addr;
    fw_word <= s1_word;
  end

  assign we    = !rst && (pass || state == CLEAR);
  assign waddr = state == CLEAR ? clr_addr : s1_addr;
  assign wdata = state == CLEAR ? clr_word : s1_word;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (take && !in_oob) pipe_q <= mem[in_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_word  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_word <= rd_oob ? '0 : mem[rd_addr];
    end
  end

  assign rd_red   = rd_word[WW-1 -: CW];
  assign rd_green = rd_word[WW-CW-1 -: CW];
  assign rd_blue  = rd_word[DW+CW-1 -: CW];
  assign rd_depth = rd_word[DW-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr_go) begin
      written_cnt  <= '0;
      rejected_cnt <= '0;
      oob_cnt      <= '0;
    end else begin
      if (pass)    written_cnt  <= sat_inc(written_cnt);
      if (reject)  rejected_cnt <= sat_inc(rejected_cnt);
      if (oob_hit) oob_cnt      <= sat_inc(oob_cnt);
    end
  end
endmodule

// File: tb/tb_zbuf_framebuffer.sv
// Bench for zbuf_framebuffer: two instances (smaller-wins and larger-wins)
// share stimulus and are checked against an in-order array model.
module tb_zbuf_framebuffer;
  localparam int HR = 64;
  localparam int VR = 48;
  localparam int NP = HR * VR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zbuf_if #(.XW(10), .YW(10), .CW(8), .DW(8)) p0 ();
  zbuf_if #(.XW(10), .YW(10), .CW(8), .DW(8)) p1 ();

  logic       in_valid;
  logic [9:0] in_x, in_y;
  logic [7:0] in_r, in_g, in_b, in_d;
  assign p0.in_valid = in_valid;
  assign p0.in_x = in_x;
  assign p0.in_y = in_y;
  assign p0.in_red = in_r;
  assign p0.in_green = in_g;
  assign p0.in_blue = in_b;
  assign p0.in_depth = in_d;
  assign p1.in_valid = in_valid;
  assign p1.in_x = in_x;
  assign p1.in_y = in_y;
  assign p1.in_red = in_r;
  assign p1.in_green = in_g;
  assign p1.in_blue = in_b;
  assign p1.in_depth = in_d;

  logic       clear_start, rd_en;
  logic [7:0] cl_r, cl_g, cl_b;
  logic [9:0] rd_x, rd_y;
  logic       busy [2];
  logic       rv [2];
  logic [7:0] rr [2], rg [2], rb [2], rdd [2];
  logic [15:0] wc [2], rc [2], oc [2];

  zbuf_framebuffer #(.DEPTH_LESS(1), .CLEAR_DEPTH(8'hFF)) dut0 (
    .clk(clk), .rst(rst), .pix(p0),
    .clear_start(clear_start), .clear_red(cl_r),
    .clear_green(cl_g), .clear_blue(cl_b), .clear_busy(busy[0]),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rv[0]),
    .rd_red(rr[0]), .rd_green(rg[0]), .rd_blue(rb[0]),
    .rd_depth(rdd[0]), .written_cnt(wc[0]),
    .rejected_cnt(rc[0]), .oob_cnt(oc[0])
  );

  zbuf_framebuffer #(.DEPTH_LESS(0), .CLEAR_DEPTH(8'h00)) dut1 (
    .clk(clk), .rst(rst), .pix(p1),
    .clear_start(clear_start), .clear_red(cl_r),
    .clear_green(cl_g), .clear_blue(cl_b), .clear_busy(busy[1]),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rv[1]),
    .rd_red(rr[1]), .rd_green(rg[1]), .rd_blue(rb[1]),
    .rd_depth(rdd[1]), .written_cnt(wc[1]),
    .rejected_cnt(rc[1]), .oob_cnt(oc[1])
  );

  logic [31:0] mdl [2][NP];
  int mw [2], mr [2], mo [2];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixels take effect strictly in arrival order.
  task automatic model_pix(input int x, input int y, input logic [31:0] w);
    for (int k = 0; k < 2; k++) begin
      if (x >= HR || y >= VR) begin
        mo[k]++;
      end else begin
        int a = y * HR + x;
        logic [7:0] od = mdl[k][a][7:0];
        logic win = (k == 0) ? (w[7:0] < od) : (w[7:0] > od);
        if (win) begin
          mdl[k][a] = w;
          mw[k]++;
        end else begin
          mr[k]++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input int x, input int y, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b,
                     input logic [7:0] d);
    in_valid = 1'b1;
    in_x = 10'(x);
    in_y = 10'(y);
    in_r = r;
    in_g = g;
    in_b = b;
    in_d = d;
    #1;
    chk("in_ready0", p0.in_ready, 1'b1);
    chk("in_ready1", p1.in_ready, 1'b1);
    model_pix(x, y, {r, g, b, d});
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_written%0d", tag, k), wc[k], 16'(mw[k]));
      chk($sformatf("%s_rejected%0d", tag, k), rc[k], 16'(mr[k]));
      chk($sformatf("%s_oob%0d", tag, k), oc[k], 16'(mo[k]));
    end
  endtask

  task automatic rd(input int x, input int y);
    rd_en = 1'b1;
    rd_x = 10'(x);
    rd_y = 10'(y);
    @(negedge clk);
    rd_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] e = (x >= HR || y >= VR) ? 32'h0 : mdl[k][y * HR + x];
      chk($sformatf("rd_valid%0d(%0d,%0d)", k, x, y), rv[k], 1'b1);
      chk($sformatf("rd_word%0d(%0d,%0d)", k, x, y),
          {rr[k], rg[k], rb[k], rdd[k]}, e);
    end
  endtask

  task automatic do_clear(input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    int n0 = 0;
    int n1 = 0;
    int n = 0;
    clear_start = 1'b1;
    cl_r = r;
    cl_g = g;
    cl_b = b;
    #1;
    chk("clr_in_ready0", p0.in_ready, 1'b0);
    chk("clr_in_ready1", p1.in_ready, 1'b0);
    @(negedge clk);
    clear_start = 1'b0;
    cl_r = ~r;
    while ((busy[0] || busy[1]) && n < 5000) begin
      n0 += int'(busy[0]);
      n1 += int'(busy[1]);
      n++;
      @(negedge clk);
    end
    chk("clear_cycles0", 64'(n0), 64'(NP + 1));
    chk("clear_cycles1", 64'(n1), 64'(NP + 1));
    for (int a = 0; a < NP; a++) begin
      mdl[0][a] = {r, g, b, 8'hFF};
      mdl[1][a] = {r, g, b, 8'h00};
    end
    for (int k = 0; k < 2; k++) begin
      mw[k] = 0;
      mr[k] = 0;
      mo[k] = 0;
    end
    chk_cnt("after_clear");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    in_d = '0;
    clear_start = 1'b0;
    cl_r = '0;
    cl_g = '0;
    cl_b = '0;
    rd_en = 1'b0;
    rd_x = '0;
    rd_y = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("rst_rd_valid%0d", k), rv[k], 1'b0);
      chk($sformatf("rst_rd_word%0d", k),
          {rr[k], rg[k], rb[k], rdd[k]}, 32'h0);
      chk($sformatf("rst_cnts%0d", k), {wc[k], rc[k], oc[k]}, 48'h0);
    end
    chk("rst_in_ready0", p0.in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready0", p0.in_ready, 1'b1);
    @(negedge clk);

    do_clear(8'd10, 8'd20, 8'd30);
    rd(0, 0);
    rd(63, 47);
    @(negedge clk);
    chk("rd_valid_idle0", rv[0], 1'b0);
    chk("rd_hold0", {rr[0], rg[0], rb[0], rdd[0]}, mdl[0][NP - 1]);

    pix(5, 5, 8'hAA, 8'hBB, 8'hCC, 8'd40);
    pix(5, 5, 8'h11, 8'h22, 8'h33, 8'd50);
    idle(2);
    chk_cnt("same55");
    rd(5, 5);

    pix(7, 3, 8'h01, 8'h02, 8'h03, 8'd80);
    pix(7, 3, 8'h04, 8'h05, 8'h06, 8'd60);
    pix(7, 3, 8'h07, 8'h08, 8'h09, 8'd70);
    idle(2);
    chk_cnt("fwd73");
    rd(7, 3);

    pix(64, 0, 8'hFF, 8'hFF, 8'hFF, 8'd0);
    pix(0, 48, 8'hFF, 8'hFF, 8'hFF, 8'd0);
    idle(2);
    chk_cnt("oob");
    rd(64, 0);
    rd(0, 0);
    rd(63, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        int x = ($urandom_range(0, 15) == 0) ? 64 + $urandom_range(0, 900)
                                            : $urandom_range(0, 3);
        int y = $urandom_range(0, 3);
        pix(x, y, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
    end
    idle(2);
    chk_cnt("random");
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) rd(x, y);

    do_clear(8'h40, 8'h50, 8'h60);
    pix(9, 9, 8'h01, 8'h01, 8'h01, 8'd5);
    pix(9, 9, 8'h02, 8'h02, 8'h02, 8'd5);
    pix(9, 9, 8'h03, 8'h03, 8'h03, 8'd9);
    idle(2);
    chk_cnt("polarity");
    rd(9, 9);

    clear_start = 1'b1;
    cl_r = 8'h77;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", p0.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("abort_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("abort_cnts%0d", k), {wc[k], rc[k], oc[k]}, 48'h0);
    end
    chk("abort_in_ready", p1.in_ready, 1'b1);
    @(negedge clk);
    do_clear(8'h12, 8'h34, 8'h56);
    rd(0, 0);
    rd(40, 30);
    rd(63, 47);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zbuf_framebuffer.md
Name: zbuf_framebuffer

Overview:
- Parametrised depth-tested framebuffer for the rasteriser back end.
- Consumes a stream of pixel records (x, y, RGB, depth) from the triangle rasteriser and performs a pipelined read-compare-write against an on-chip colour and depth store.
- Provides a framebuffer clear mode and a synchronous read port for the display scan-out.
- Generalises the fixed 10-bit coordinate, 8-bit channel and 8-bit depth pixel format to configurable widths and depth-compare polarity.

Parameters:
- XW, 10, x coordinate width
- YW, 10, y coordinate width
- CW, 8, width of each colour channel
- DW, 8, depth width
- H_RES, 64, stored columns (H_RES <= 2**XW)
- V_RES, 48, stored rows (V_RES <= 2**YW)
- DEPTH_LESS, 1, 1: smaller depth wins; 0: larger depth wins
- CLEAR_DEPTH, {DW{1'b1}}, depth written by clear
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_x  in  XW  pixel column
- in_y  in  YW  pixel row
- in_red/in_green/in_blue  in  CW each  pixel colour
- in_depth  in  DW  pixel depth
- clear_start  in  1  one-cycle clear request
- clear_red/clear_green/clear_blue  in  CW each  clear colour, sampled with clear_start
- clear_busy  out  1  clear in progress
- rd_en  in  1  scan-out read request
- rd_x  in  XW  read column
- rd_y  in  YW  read row
- rd_valid  out  1  read data valid
- rd_red/rd_green/rd_blue  out  CW each  read colour
- rd_depth  out  DW  read depth
- written_cnt  out  CNT_W  pixels that passed the depth test
- rejected_cnt  out  CNT_W  pixels that failed the depth test
- oob_cnt  out  CNT_W  out-of-range pixels dropped

Behaviour:
- Reset (rst high at a clock edge):
  - All outputs go to 0; state goes to RUN; the pipeline is emptied.
  - in_ready is forced 0 during any cycle in which rst is high.
  - Store contents are not altered; a clear in progress is aborted.
- Storage:
  - Array of H_RES*V_RES words of {r,g,b,depth}.
  - Address = y*H_RES + x.
  - One write port and two synchronous read ports (pipeline and scan-out).
- FSM states: RUN, DRAIN, CLEAR.
  - RUN: in_ready=1.
  - clear_start sampled high in RUN: latch the clear colour; go to DRAIN; in_ready=0 from that same cycle (combinational on clear_start).
  - DRAIN: one cycle; the compare-stage pixel completes; go to CLEAR.
  - CLEAR: writes clear colour and CLEAR_DEPTH to addresses 0..H_RES*V_RES-1, one per cycle, in ascending order; returns to RUN after the last write.
  - clear_busy=1 in DRAIN and CLEAR; clear_start is ignored while busy.
  - On clear_start, all three counters reset to 0.
- Pixel pipeline (1 pixel/cycle, no bubbles):
  - Cycle t: pixel accepted; stored word read at its address.
  - Cycle t+1, compare stage: pass if DEPTH_LESS ? in_depth < stored : in_depth > stored. Equal depth is rejected.
  - On pass, the word is written at end of t+1 and written_cnt increments; otherwise rejected_cnt increments.
- Forwarding: if the compare-stage pixel at cycle t+1 has the same address as the pixel written at end of cycle t, compare against that forwarded word, not the stale read. Back-to-back same-address pixels must resolve in arrival order.
- Out of range (x>=H_RES or y>=V_RES): accepted, no access, oob_cnt increments at t+1.
- Counters saturate at all ones.
- Scan-out:
  - rd_en at cycle t gives rd_valid and data at t+1; otherwise rd_valid=0 and data holds.
  - An out-of-range read returns all zeros with rd_valid=1.
  - A write at end of cycle t is visible to reads issued at t+1 or later.
  - Reads are permitted during CLEAR and return current contents.

Test Plan:
- Clear with colour 10/20/30, DEPTH_LESS=1 -> clear_busy high for 1+3072 cycles; reading (0,0) and (63,47) returns 10/20/30, depth FF.
- After clear, write (5,5) depth 40 colour AA/BB/CC, then (5,5) depth 50 colour 11/22/33 -> read returns AA/BB/CC depth 40; written_cnt=1, rejected_cnt=1.
- Back-to-back same-address pixels at (7,3) with depths 80, 60, 70 on consecutive cycles -> forwarding applies; final depth 60; written 2, rejected 1.
- Pixel at (64,0) and (0,48) -> oob_cnt=2; store unchanged; read of (64,0) returns zeros with rd_valid=1.
- DEPTH_LESS=0: depth 5 then depth 5 then depth 9 at the same address, after clearing with CLEAR_DEPTH=0 -> final depth 9; equal-depth pixel rejected.
- Assert rst 100 cycles into a clear -> next cycle clear_busy=0, in_ready=1, counters 0; clear_start is honoured again afterwards.
